// File: rtl/alloc_pkg.sv
// rtl/alloc_pkg.sv - shared types and constants for the strip-packing allocator path
package alloc_pkg;

    // Default dimension field width and issue cadence shared with the allocator
    localparam int DIM_W       = 5;
    localparam int SLOT_CYCLES = 4;
    localparam int ARRAY_SIZE  = 128;
    localparam int IDX_W       = $clog2(ARRAY_SIZE);

    // One program size request as seen by the allocator
    typedef struct packed {
        logic [DIM_W-1:0] height;
        logic [DIM_W-1:0] width;
    } alloc_req_t;

    // Placement result produced by the allocator for downstream consumers
    typedef struct packed {
        logic             strike;
        logic [IDX_W-1:0] index_x;
        logic [IDX_W-1:0] index_y;
    } alloc_result_t;

    // A request with either dimension zero carries no program and is dropped
    function automatic logic is_zero_req(input alloc_req_t req);
        return (req.height == '0) || (req.width == '0);
    endfunction

endpackage

// File: rtl/alloc_req_fifo.sv
// rtl/alloc_req_fifo.sv - synchronous request FIFO with occupancy count
module alloc_req_fifo
    import alloc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = $bits(alloc_req_t)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // Full/empty come from the count so pointer equality never has to be decoded
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage is deliberately not reset; only the pointers define valid entries
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alloc_req_issuer.sv
// rtl/alloc_req_issuer.sv - buffers size requests and issues one per fixed slot
module alloc_req_issuer #(
    parameter int DEPTH       = 8,
    parameter int SLOT_CYCLES = alloc_pkg::SLOT_CYCLES,
    parameter int DIM_W       = alloc_pkg::DIM_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [DIM_W-1:0]           req_height_i,
    input  logic [DIM_W-1:0]           req_width_i,
    output logic [DIM_W-1:0]           height_o,
    output logic [DIM_W-1:0]           width_o,
    output logic                       issue_o,
    output logic [1:0]                 slot_phase_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
    output logic [15:0]                issued_count_o,
    output logic [7:0]                 zero_drop_count_o
);

    localparam int         CW         = $clog2(DEPTH+1);
    localparam logic [1:0] LAST_PHASE = 2'(SLOT_CYCLES - 1);

    logic [1:0]         r_phase;
    logic [DIM_W-1:0]   r_height;
    logic [DIM_W-1:0]   r_width;
    logic               r_issue;
    logic [15:0]        r_issued;
    logic [7:0]         r_zero_drop;

    logic               w_boundary;
    logic               w_accept;
    logic               w_zero;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [2*DIM_W-1:0] w_head;
    logic [CW-1:0]      w_count;

    // Ready depends only on occupancy, so a full FIFO stays closed even on a popping edge
    assign req_ready_o = !w_full;
    assign w_boundary  = (r_phase == LAST_PHASE);
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_zero      = (req_height_i == '0) || (req_width_i == '0);
    assign w_push      = w_accept && !w_zero;
    // Pop decision uses pre-edge emptiness, so a request arriving on the boundary waits a slot
    assign w_pop       = w_boundary && !w_empty;

    alloc_req_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (2*DIM_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_data  ({req_height_i, req_width_i}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Free-running slot phase counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_phase <= '0;
        end else if (w_boundary) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 2'd1;
        end
    end

    // Load the head (or a bubble) at each slot boundary and hold it for the whole slot
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_height <= '0;
            r_width  <= '0;
            r_issue  <= 1'b0;
        end else if (w_boundary) begin
            r_height <= w_empty ? '0 : w_head[2*DIM_W-1:DIM_W];
            r_width  <= w_empty ? '0 : w_head[DIM_W-1:0];
            r_issue  <= !w_empty;
        end else begin
            r_issue  <= 1'b0;
        end
    end

    // Issue counter wraps; zero-dimension drop counter saturates
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_issued    <= '0;
            r_zero_drop <= '0;
        end else begin
            if (w_pop) begin
                r_issued <= r_issued + 16'd1;
            end
            if (w_accept && w_zero && (r_zero_drop != 8'hFF)) begin
                r_zero_drop <= r_zero_drop + 8'd1;
            end
        end
    end

    assign height_o          = r_height;
    assign width_o           = r_width;
    assign issue_o           = r_issue;
    assign slot_phase_o      = r_phase;
    assign fifo_count_o      = w_count;
    assign issued_count_o    = r_issued;
    assign zero_drop_count_o = r_zero_drop;

endmodule

// File: tb/tb_alloc_req_issuer.sv
// tb/tb_alloc_req_issuer.sv - scoreboard bench for alloc_req_issuer
module tb_alloc_req_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [4:0]  rh  = '0;
    logic [4:0]  rw  = '0;
    logic        ready;
    logic [4:0]  h_o;
    logic [4:0]  w_o;
    logic        issue;
    logic [1:0]  phase;
    logic [3:0]  count;
    logic [15:0] issued;
    logic [7:0]  zdrop;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_issued = 0;
    int          exp_zd     = 0;
    logic [9:0]  exp_q [$];
    logic [9:0]  mon_e;
    logic [4:0]  prev_h = '0;
    logic [4:0]  prev_w = '0;

    alloc_req_issuer #(.DEPTH(8), .SLOT_CYCLES(4), .DIM_W(5)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (vld),
        .req_ready_o       (ready),
        .req_height_i      (rh),
        .req_width_i       (rw),
        .height_o          (h_o),
        .width_o           (w_o),
        .issue_o           (issue),
        .slot_phase_o      (phase),
        .fifo_count_o      (count),
        .issued_count_o    (issued),
        .zero_drop_count_o (zdrop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: issued values come off the scoreboard, otherwise bubble or hold
    always @(negedge clk) begin
        if (!rst) begin
            if (issue) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 32'(issue), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("issue_height", 32'(h_o), 32'(mon_e[9:5]));
                    check("issue_width", 32'(w_o), 32'(mon_e[4:0]));
                    check("issue_phase", 32'(phase), 0);
                    exp_issued++;
                end
            end else if (phase == 2'd0) begin
                check("bubble_height", 32'(h_o), 0);
                check("bubble_width", 32'(w_o), 0);
            end else begin
                check("hold_height", 32'(h_o), 32'(prev_h));
                check("hold_width", 32'(w_o), 32'(prev_w));
            end
            prev_h = h_o;
            prev_w = w_o;
        end else begin
            prev_h = '0;
            prev_w = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int p);
        for (int k = 0; k < 16 && 32'(phase) != p; k++) tick();
        check("wait_phase", 32'(phase), p);
    endtask

    task automatic push(input logic [4:0] h, input logic [4:0] w);
        for (int k = 0; k < 40 && !ready; k++) tick();
        check("push_ready", 32'(ready), 1);
        vld = 1'b1;
        rh  = h;
        rw  = w;
        if (h != 5'd0 && w != 5'd0) exp_q.push_back({h, w});
        else if (exp_zd < 255) exp_zd++;
        tick();
        vld = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && (exp_q.size() != 0 || count != 4'd0); k++) tick();
        tick();
        check("drain_queue", exp_q.size(), 0);
        check("drain_count", 32'(count), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_height"}, 32'(h_o), 0);
        check({tag, "_width"}, 32'(w_o), 0);
        check({tag, "_issue"}, 32'(issue), 0);
        check({tag, "_phase"}, 32'(phase), 0);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_issued"}, 32'(issued), 0);
        check({tag, "_zdrop"}, 32'(zdrop), 0);
        check({tag, "_ready"}, 32'(ready), 1);
    endtask

    initial begin
        int exp_phase;
        int sent;
        int p;
        int c;
        bit full_seen;

        // Reset and idle phase sequence
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        exp_phase = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_phase = (exp_phase + 1) % 4;
            check("idle_phase", 32'(phase), exp_phase);
        end

        // Single request pushed mid-slot
        wait_phase(2);
        push(5'd12, 5'd20);
        wait_drain();
        check("issued_after_single", 32'(issued), 1);
        check("issued_model_single", 32'(issued), exp_issued);

        // Burst until full, no acceptance while full, order preserved
        sent = 0;
        full_seen = 1'b0;
        for (int k = 0; k < 40 && !full_seen; k++) begin
            if (count == 4'd8) begin
                full_seen = 1'b1;
            end else begin
                vld = 1'b1;
                rh  = 5'(sent + 1);
                rw  = 5'(31 - sent);
                exp_q.push_back({rh, rw});
                sent++;
                tick();
            end
        end
        check("full_reached", 32'(full_seen), 1);
        check("full_ready", 32'(ready), 0);
        check("full_count", 32'(count), 8);
        p  = 32'(phase);
        rh = 5'd31;
        rw = 5'd31;
        tick();
        check("no_bypass_full", 32'(count), (p == 3) ? 7 : 8);
        vld = 1'b0;
        wait_phase(0);
        check("pop_from_full_count", 32'(count), 7);
        check("ready_after_pop", 32'(ready), 1);
        wait_drain();
        check("issued_after_burst", 32'(issued), exp_issued);

        // Zero-dimension requests complete the handshake but are dropped
        push(5'd0, 5'd5);
        push(5'd5, 5'd0);
        tick();
        check("zero_drop_count", 32'(zdrop), exp_zd);
        check("zero_drop_two", 32'(zdrop), 2);
        check("zero_drop_fifo", 32'(count), 0);

        // Reset mid-slot with requests still buffered
        wait_phase(0);
        push(5'd3, 5'd4);
        push(5'd6, 5'd7);
        push(5'd8, 5'd9);
        wait_phase(1);
        check("pre_reset_count", 32'(count), 2);
        check("pre_reset_queue", exp_q.size(), 2);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_issued = 0;
        exp_zd = 0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("post_reset_count", 32'(count), 0);
        check("post_reset_issued", 32'(issued), 0);

        // Push landing on the boundary edge waits a full slot
        wait_phase(3);
        push(5'd7, 5'd9);
        check("boundary_push_phase", 32'(phase), 0);
        check("boundary_push_no_issue", 32'(issue), 0);
        check("boundary_push_bubble", 32'(h_o), 0);
        c = 0;
        while (!issue && c < 12) begin
            tick();
            c++;
        end
        check("boundary_push_latency", c, 4);
        wait_drain();
        check("issued_after_boundary", 32'(issued), exp_issued);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
